// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// instruction/byte widths and small datapath helpers.
package prog_loader_pkg;

   localparam int INSTR_W = 16;
   localparam int BYTE_W  = 8;

   localparam logic [3:0]         OPC_HALT  = 4'h0;
   localparam logic [INSTR_W-1:0] HALT_WORD = {OPC_HALT, 12'h000};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
      ST_CHK  = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } loader_state_t;

   // Frame checksum is a plain 8-bit running sum that wraps.
   function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] sum,
                                                  input logic [BYTE_W-1:0] data);
      return sum + data;
   endfunction

   function automatic logic is_loading(input loader_state_t st);
      return (st == ST_LEN) || (st == ST_HI) || (st == ST_LO) || (st == ST_CHK);
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready byte stream carrying a framed program into the loader.
interface prog_loader_if;
   import prog_loader_pkg::*;

   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/prog_loader_ram.sv
// Program store: one synchronous write port, one asynchronous read port.
// Deliberately not reset; the loader tracks validity through words_loaded.
module prog_loader_ram
   import prog_loader_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem_r [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader and instruction store; holds the MCU in reset
// until a complete frame with a good checksum has been committed.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 100000,
   parameter int TO_W    = 17
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   prog_loader_if.slave       rx,
   input  logic [ADDR_W-1:0]  pc,
   output logic [INSTR_W-1:0] ir,
   output logic               cpu_reset,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [ADDR_W:0]    words_loaded
);

   localparam int                RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_LEN_C = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_ADR_C = ADDR_W'(1);
   localparam logic [TO_W-1:0]   TO_LAST_C = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0]   TO_ONE_C  = TO_W'(1);

   loader_state_t     state_r, state_nx_s;
   logic [BYTE_W-1:0] hi_byte_r, hi_nx_s;
   logic [BYTE_W-1:0] sum_r, sum_nx_s;
   logic [ADDR_W-1:0] addr_r, addr_nx_s;
   logic [ADDR_W:0]   pending_len_r, plen_nx_s;
   logic [TO_W-1:0]   to_cnt_r, to_nx_s;
   logic [ADDR_W:0]   words_loaded_r, wl_nx_s;
   logic              done_r, done_nx_s;
   logic              err_r, err_nx_s;
   logic              busy_r, busy_nx_s;
   logic              cpu_reset_r, cpu_rst_nx_s;
   logic              rx_ready_r;

   logic               accept_s;
   logic [ADDR_W:0]    len_s;
   logic               we_s;
   logic [INSTR_W-1:0] wdata_s;
   logic [INSTR_W-1:0] ram_rd_s;

   assign accept_s = rx.rx_valid && rx_ready_r;
   assign len_s    = (ADDR_W+1)'(rx.rx_data);
   assign wdata_s  = {hi_byte_r, rx.rx_data};

   // Next-state, datapath and status computation
   always_comb begin
      state_nx_s   = state_r;
      hi_nx_s      = hi_byte_r;
      sum_nx_s     = sum_r;
      addr_nx_s    = addr_r;
      plen_nx_s    = pending_len_r;
      to_nx_s      = to_cnt_r;
      wl_nx_s      = words_loaded_r;
      done_nx_s    = done_r;
      err_nx_s     = err_r;
      busy_nx_s    = busy_r;
      cpu_rst_nx_s = cpu_reset_r;
      we_s         = 1'b0;

      // Idle-gap watchdog; only a stalled stream can trip it, so it never races a byte transition.
      if (is_loading(state_r)) begin
         if (accept_s) begin
            to_nx_s = '0;
         end else if (to_cnt_r == TO_LAST_C) begin
            to_nx_s    = '0;
            state_nx_s = ST_ERR;
         end else begin
            to_nx_s = to_cnt_r + TO_ONE_C;
         end
      end else begin
         to_nx_s = '0;
      end

      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_nx_s   = ST_LEN;
               cpu_rst_nx_s = 1'b1;
               done_nx_s    = 1'b0;
               err_nx_s     = 1'b0;
               busy_nx_s    = 1'b1;
               wl_nx_s      = '0;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_LEN: begin
            if (accept_s) begin
               if ((len_s == '0) || (len_s > DEPTH_C)) begin
                  state_nx_s = ST_ERR;
               end else begin
                  plen_nx_s  = len_s;
                  addr_nx_s  = '0;
                  sum_nx_s   = '0;
                  state_nx_s = ST_HI;
               end
            end else begin
               plen_nx_s = pending_len_r;
            end
         end
         ST_HI: begin
            if (accept_s) begin
               hi_nx_s    = rx.rx_data;
               sum_nx_s   = csum_add(sum_r, rx.rx_data);
               state_nx_s = ST_LO;
            end else begin
               hi_nx_s = hi_byte_r;
            end
         end
         ST_LO: begin
            if (accept_s) begin
               we_s      = 1'b1;
               sum_nx_s  = csum_add(sum_r, rx.rx_data);
               addr_nx_s = addr_r + ONE_ADR_C;
               if ({1'b0, addr_r} == (pending_len_r - ONE_LEN_C)) begin
                  state_nx_s = ST_CHK;
               end else begin
                  state_nx_s = ST_HI;
               end
            end else begin
               we_s = 1'b0;
            end
         end
         ST_CHK: begin
            if (accept_s) begin
               if (rx.rx_data == sum_r) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_ERR;
               end
            end else begin
               sum_nx_s = sum_r;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase

      // Terminal-state status; re-applying it while parked there is a no-op.
      case (state_nx_s)
         ST_DONE: begin
            wl_nx_s      = pending_len_r;
            done_nx_s    = 1'b1;
            busy_nx_s    = 1'b0;
            cpu_rst_nx_s = 1'b0;
         end
         ST_ERR: begin
            wl_nx_s      = '0;
            err_nx_s     = 1'b1;
            busy_nx_s    = 1'b0;
            cpu_rst_nx_s = 1'b1;
         end
         default: begin
            busy_nx_s = busy_nx_s;
         end
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         hi_byte_r      <= '0;
         sum_r          <= '0;
         addr_r         <= '0;
         pending_len_r  <= '0;
         to_cnt_r       <= '0;
         words_loaded_r <= '0;
         done_r         <= 1'b0;
         err_r          <= 1'b0;
         busy_r         <= 1'b0;
         cpu_reset_r    <= 1'b1;
         rx_ready_r     <= 1'b0;
      end else begin
         state_r        <= state_nx_s;
         hi_byte_r      <= hi_nx_s;
         sum_r          <= sum_nx_s;
         addr_r         <= addr_nx_s;
         pending_len_r  <= plen_nx_s;
         to_cnt_r       <= to_nx_s;
         words_loaded_r <= wl_nx_s;
         done_r         <= done_nx_s;
         err_r          <= err_nx_s;
         busy_r         <= busy_nx_s;
         cpu_reset_r    <= cpu_rst_nx_s;
         rx_ready_r     <= is_loading(state_nx_s);
      end
   end

   prog_loader_ram #(
      .DEPTH (DEPTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr (addr_r[RAM_AW-1:0]),
      .wdata (wdata_s),
      .raddr (pc[RAM_AW-1:0]),
      .rdata (ram_rd_s)
   );

   // pc < words_loaded implies pc < DEPTH, so the truncated RAM index is safe.
   assign ir           = ({1'b0, pc} < words_loaded_r) ? ram_rd_s : HALT_WORD;
   assign rx.rx_ready  = rx_ready_r;
   assign cpu_reset    = cpu_reset_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign err          = err_r;
   assign words_loaded = words_loaded_r;

endmodule
